// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor and other CLK-domain consumers.
//   state_t   : monitor FSM encoding (SEARCH=0, MEASURE=1, LOCKED=2)
//   cnt_width : bits needed to hold a counter value 0..max_val
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the divided-clock monitor and its surroundings.
//   CLK_DIV_IN  : divided clock under test (sampled as data in the CLK domain)
//   RISE_STB / FALL_STB : 1-cycle edge strobes
//   LOCKED, PERIOD_ERR, DUTY_ERR, ERR_COUNT, STUCK : monitor status
//   STATE       : debug view of the monitor FSM
// Modports: slave = the monitor, master = the source/consumer side.
// There is no valid/ready handshake here: every output is a level or a
// single-cycle pulse qualified only by the CLK edge it is registered on.
interface clk_div_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    import clk_mon_pkg::*;

    logic                 CLK_DIV_IN;
    logic                 RISE_STB;
    logic                 FALL_STB;
    logic                 LOCKED;
    logic                 PERIOD_ERR;
    logic                 DUTY_ERR;
    logic [ERR_CNT_W-1:0] ERR_COUNT;
    logic                 STUCK;
    state_t               STATE;

    modport slave (
        input  CLK_DIV_IN,
        output RISE_STB, FALL_STB, LOCKED, PERIOD_ERR, DUTY_ERR,
               ERR_COUNT, STUCK, STATE
    );

    modport master (
        output CLK_DIV_IN,
        input  RISE_STB, FALL_STB, LOCKED, PERIOD_ERR, DUTY_ERR,
               ERR_COUNT, STUCK, STATE
    );

endinterface

// File: rtl/clk_edge_det.sv
// Edge detector for a slow signal sampled in the CLK domain.
//   clk, rst_n : CLK and asynchronous active-low reset
//   din        : sampled input
//   rise, fall : combinational edge indications for the current sample
//   rise_stb, fall_stb : the same, registered (1-cycle latency, 1-cycle wide)
module clk_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic rise_stb,
    output logic fall_stb
);

    logic prev;

    assign rise = din & ~prev;
    assign fall = ~din & prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            prev     <= din;
            rise_stb <= rise;
            fall_stb <= fall;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock sampled in the CLK domain.
// Measures period and high time in CLK cycles, flags mismatches, keeps a
// saturating error count and declares lock after LOCK_COUNT good periods.
//   CLK, RESET_L : reference clock, asynchronous active-low reset
//   mon (slave)  : CLK_DIV_IN in; strobes, status, ERR_COUNT and STATE out
// Optional feature: define CLK_DIV_MONITOR_STUCK_EN to enable a watchdog that
// drops back to SEARCH and raises STUCK when no rise arrives within
// 2*DIV_RATIO cycles. Without it STUCK is tied low.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int DIV_RATIO   = 4,
    parameter int HIGH_CYCLES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RESET_L,
    clk_div_monitor_if.slave   mon
);

    localparam int PER_MAX = 2 * DIV_RATIO;
    localparam int CW      = cnt_width(PER_MAX);
    localparam int GW      = cnt_width(LOCK_COUNT);
    localparam logic [ERR_CNT_W+1:0] ERR_MAX = {2'b00, {ERR_CNT_W{1'b1}}};

    logic                 rise, fall;
    logic [CW-1:0]        per_cnt, hi_cnt;
    logic [GW-1:0]        good_cnt, good_nxt;
    logic                 fall_ok;
    state_t               state, state_nxt;
    logic                 period_err_nxt, duty_err_nxt, period_good;
    logic                 stuck_evt;
    logic                 period_err_q, duty_err_q;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ERR_CNT_W+1:0] err_sum;

    clk_edge_det u_edge (
        .clk      (CLK),
        .rst_n    (RESET_L),
        .din      (mon.CLK_DIV_IN),
        .rise     (rise),
        .fall     (fall),
        .rise_stb (mon.RISE_STB),
        .fall_stb (mon.FALL_STB)
    );

    // Checks run only once a first rise has aligned the counters.
    assign duty_err_nxt   = fall & (state != ST_SEARCH) & (hi_cnt  != CW'(HIGH_CYCLES));
    assign period_err_nxt = rise & (state != ST_SEARCH) & (per_cnt != CW'(DIV_RATIO));
    // A period is good when its own length and the duty check inside it passed.
    assign period_good    = ~period_err_nxt & fall_ok;

    // Period / high-time counters; both restart at 1 on the rise sample.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            fall_ok <= 1'b0;
        end else begin
            if (rise)
                per_cnt <= CW'(1);
            else if (per_cnt != CW'(PER_MAX))
                per_cnt <= per_cnt + CW'(1);

            if (rise)
                hi_cnt <= CW'(1);
            else if (mon.CLK_DIV_IN && (hi_cnt != CW'(PER_MAX)))
                hi_cnt <= hi_cnt + CW'(1);

            if (rise)
                fall_ok <= 1'b0;
            else if (fall && (state != ST_SEARCH))
                fall_ok <= (hi_cnt == CW'(HIGH_CYCLES));
        end
    end

    // FSM next state. Lock decisions are made only on rise samples.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        stuck_evt = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    if (!period_good) begin
                        good_nxt = '0;
                    end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                        good_nxt  = GW'(LOCK_COUNT);
                        state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = good_cnt + GW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (rise && !period_good) begin
                    state_nxt = ST_MEASURE;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
                good_nxt  = '0;
            end
        endcase
`ifdef CLK_DIV_MONITOR_STUCK_EN
        // per_cnt is about to reach its saturation value without a rise.
        if ((state != ST_SEARCH) && !rise && (per_cnt == CW'(PER_MAX - 1))) begin
            stuck_evt = 1'b1;
            state_nxt = ST_SEARCH;
            good_nxt  = '0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Two spare bits so simultaneous events can never wrap before clamping.
    assign err_sum = {2'b00, err_cnt}
                   + (ERR_CNT_W+2)'(period_err_nxt)
                   + (ERR_CNT_W+2)'(duty_err_nxt)
                   + (ERR_CNT_W+2)'(stuck_evt);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            period_err_q <= 1'b0;
            duty_err_q   <= 1'b0;
            err_cnt      <= '0;
        end else begin
            period_err_q <= period_err_nxt;
            duty_err_q   <= duty_err_nxt;
            err_cnt      <= (err_sum > ERR_MAX) ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
        end
    end

`ifdef CLK_DIV_MONITOR_STUCK_EN
    logic stuck_q;
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L)
            stuck_q <= 1'b0;
        else if (stuck_evt)
            stuck_q <= 1'b1;
        else if (rise)
            stuck_q <= 1'b0;
    end
    assign mon.STUCK = stuck_q;
`else
    assign mon.STUCK = 1'b0;
`endif

    assign mon.LOCKED     = (state == ST_LOCKED);
    assign mon.PERIOD_ERR = period_err_q;
    assign mon.DUTY_ERR   = duty_err_q;
    assign mon.ERR_COUNT  = err_cnt;
    assign mon.STATE      = state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor (DIV_RATIO=4, HIGH_CYCLES=2,
// LOCK_COUNT=4, ERR_CNT_W=8). Inputs change 1 ns after posedge CLK and
// outputs are read at that point, i.e. they reflect the sample just taken.
module tb_clk_div_monitor;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rise_n = 0, fall_n = 0, perr_n = 0, derr_n = 0;
    int   r0, f0, p0, d0;
    logic [7:0] exp_q[$];

    clk_div_monitor_if #(.ERR_CNT_W(8)) mon_if ();

    clk_div_monitor #(
        .DIV_RATIO   (4),
        .HIGH_CYCLES (2),
        .LOCK_COUNT  (4),
        .ERR_CNT_W   (8)
    ) dut (
        .CLK     (clk),
        .RESET_L (rst_n),
        .mon     (mon_if.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_if.RISE_STB)   rise_n++;
        if (mon_if.FALL_STB)   fall_n++;
        if (mon_if.PERIOD_ERR) perr_n++;
        if (mon_if.DUTY_ERR)   derr_n++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard: expected ERR_COUNT values are queued, then popped and compared
    task automatic check_err_count(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        check_eq(tag, {24'd0, mon_if.ERR_COUNT}, {24'd0, exp_q.pop_front()});
    endtask

    // driver tasks
    task automatic drive_cycle(input logic v);
        mon_if.CLK_DIV_IN = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int hi, input int lo);
        for (int i = 0; i < hi; i++) drive_cycle(1'b1);
        for (int i = 0; i < lo; i++) drive_cycle(1'b0);
    endtask

    task automatic finish_period;
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        mon_if.CLK_DIV_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rise_stb",   mon_if.RISE_STB, 0);
        check_eq("rst_fall_stb",   mon_if.FALL_STB, 0);
        check_eq("rst_locked",     mon_if.LOCKED, 0);
        check_eq("rst_period_err", mon_if.PERIOD_ERR, 0);
        check_eq("rst_duty_err",   mon_if.DUTY_ERR, 0);
        check_eq("rst_stuck",      mon_if.STUCK, 0);
        check_eq("rst_state",      mon_if.STATE, 0);
        check_err_count("rst_err_count", 8'd0);
        rst_n = 1'b1;
        drive_cycle(1'b0);
        drive_cycle(1'b0);

        // 1: clean /4 input, lock at 5th rise
        r0 = rise_n; f0 = fall_n; p0 = perr_n; d0 = derr_n;
        repeat (4) drive_period(2, 2);
        check_eq("t1_unlocked_4th", mon_if.LOCKED, 0);
        check_eq("t1_state_measure", mon_if.STATE, 1);
        drive_cycle(1'b1);
        check_eq("t1_rise_stb", mon_if.RISE_STB, 1);
        check_eq("t1_locked_5th", mon_if.LOCKED, 1);
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        check_eq("t1_fall_stb", mon_if.FALL_STB, 1);
        drive_cycle(1'b0);
        check_eq("t1_rise_count", rise_n - r0, 5);
        check_eq("t1_fall_count", fall_n - f0, 5);
        check_eq("t1_perr_count", perr_n - p0, 0);
        check_eq("t1_derr_count", derr_n - d0, 0);
        check_err_count("t1_err_count", 8'd0);

        // 2: one period stretched to 5
        drive_period(2, 3);
        drive_cycle(1'b1);
        check_eq("t2_period_err", mon_if.PERIOD_ERR, 1);
        check_eq("t2_unlocked", mon_if.LOCKED, 0);
        check_err_count("t2_err_count", 8'd1);
        drive_cycle(1'b1);
        check_eq("t2_period_err_pulse", mon_if.PERIOD_ERR, 0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        repeat (3) drive_period(2, 2);
        check_eq("t2_not_yet_relocked", mon_if.LOCKED, 0);
        drive_cycle(1'b1);
        check_eq("t2_relocked", mon_if.LOCKED, 1);
        finish_period();

        // 3: high time 3, period 4
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        check_eq("t3_duty_err", mon_if.DUTY_ERR, 1);
        check_eq("t3_still_locked", mon_if.LOCKED, 1);
        check_err_count("t3_err_count_fall", 8'd2);
        drive_cycle(1'b1);
        check_eq("t3_no_period_err", mon_if.PERIOD_ERR, 0);
        check_eq("t3_unlocked", mon_if.LOCKED, 0);
        check_err_count("t3_err_count_rise", 8'd2);
        finish_period();

        // 4: input held low
        repeat (20) drive_cycle(1'b0);
`ifdef CLK_DIV_MONITOR_STUCK_EN
        check_eq("t4_stuck", mon_if.STUCK, 1);
        check_eq("t4_state_search", mon_if.STATE, 0);
        check_err_count("t4_err_count_hold", 8'd3);
        drive_cycle(1'b1);
        check_eq("t4_no_period_err", mon_if.PERIOD_ERR, 0);
        check_eq("t4_stuck_cleared", mon_if.STUCK, 0);
`else
        check_eq("t4_stuck", mon_if.STUCK, 0);
        check_eq("t4_state_measure", mon_if.STATE, 1);
        check_err_count("t4_err_count_hold", 8'd2);
        drive_cycle(1'b1);
        check_eq("t4_period_err", mon_if.PERIOD_ERR, 1);
`endif
        check_eq("t4_state_after_rise", mon_if.STATE, 1);
        check_err_count("t4_err_count_rise", 8'd3);
        finish_period();

        // 6: reset while locked, right after a rise strobe
        repeat (3) drive_period(2, 2);
        drive_cycle(1'b1);
        check_eq("t6_locked_before_rst", mon_if.LOCKED, 1);
        check_eq("t6_rise_stb_before_rst", mon_if.RISE_STB, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_locked", mon_if.LOCKED, 0);
        check_eq("t6_rst_rise_stb", mon_if.RISE_STB, 0);
        check_eq("t6_rst_state", mon_if.STATE, 0);
        check_err_count("t6_rst_err_count", 8'd0);
        mon_if.CLK_DIV_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b0);
        repeat (4) drive_period(2, 2);
        check_eq("t6_unlocked_4th", mon_if.LOCKED, 0);
        drive_cycle(1'b1);
        check_eq("t6_relocked_5th", mon_if.LOCKED, 1);
        finish_period();

        // 5: period 5 / high 3 gives a duty and a period error per period
        repeat (10) drive_period(3, 2);
        check_err_count("t5_err_count_19", 8'd19);
        check_eq("t5_unlocked", mon_if.LOCKED, 0);
        repeat (150) drive_period(3, 2);
        check_err_count("t5_err_count_sat", 8'd255);
        drive_cycle(1'b1);
        check_err_count("t5_err_count_held", 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
